// File: rtl/lsb_embed.sv
// ---------------------------------------------------------------------------
// lsb_embed
//   LSB-steganography embedding stage between the image reader and the .bmp
//   writer. Each even/odd RGB888 pixel pair that arrives with hsync_in gets
//   up to six message bits written into its colour-byte LSBs. The bits go in
//   the order R0, G0, B0, R1, G1, B1. The pair is forwarded one cycle later
//   with a matching hsync_out.
//
// Ports
//   HCLK, HRESET                clock (rising edge), async active-high reset
//   hsync_in                    one pixel pair valid per asserted cycle
//   DATA_{R,G,B}{0,1}_in        even/odd pixel colour bytes
//   msg_valid/msg_data/msg_last message byte stream, MSB embedded first
//   msg_ready                   byte accepted when msg_valid && msg_ready
//   hsync_out                   hsync_in delayed by one cycle
//   DATA_{R,G,B}{0,1}_out       embedded pixel pair
//   bits_embedded               saturating count of bits written into pixels
//   embed_done                  sticky, final byte fully embedded
//   underrun                    sticky, pair seen with fewer than 6 bits buffered
//   overflow                    sticky, frame ended before the message did
// ---------------------------------------------------------------------------
module lsb_embed #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int CNT_W  = 22
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             hsync_in,
  input  logic [7:0]       DATA_R0_in,
  input  logic [7:0]       DATA_G0_in,
  input  logic [7:0]       DATA_B0_in,
  input  logic [7:0]       DATA_R1_in,
  input  logic [7:0]       DATA_G1_in,
  input  logic [7:0]       DATA_B1_in,
  input  logic             msg_valid,
  input  logic [7:0]       msg_data,
  input  logic             msg_last,
  output logic             msg_ready,
  output logic             hsync_out,
  output logic [7:0]       DATA_R0_out,
  output logic [7:0]       DATA_G0_out,
  output logic [7:0]       DATA_B0_out,
  output logic [7:0]       DATA_R1_out,
  output logic [7:0]       DATA_G1_out,
  output logic [7:0]       DATA_B1_out,
  output logic [CNT_W-1:0] bits_embedded,
  output logic             embed_done,
  output logic             underrun,
  output logic             overflow
);

  localparam int PAIRS = WIDTH * HEIGHT / 2;

  typedef enum logic [1:0] {IDLE, EMBED, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [15:0]      buf_q, buf_nxt;
  logic [4:0]       buf_cnt, cnt_nxt;
  logic [CNT_W-1:0] pair_cnt;

  logic             frame_done;
  logic             accept;
  logic             consume_en;
  logic             underrun_hit;
  logic [2:0]       k;
  logic [4:0]       remain;
  logic [15:0]      buf_shift;
  logic [CNT_W:0]   bits_sum;
  logic [7:0]       pix_in  [6];
  logic [7:0]       pix_emb [6];

  // Once PAIRS pairs have gone by the frame is over: the buffer freezes and
  // every later pair passes straight through.
  assign frame_done = (pair_cnt == CNT_W'(PAIRS));

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = msg_last ? DRAIN : EMBED;
      EMBED:   if (accept && msg_last) state_nxt = DRAIN;
      DRAIN:   if (cnt_nxt == 5'd0) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs. msg_ready is gated by HRESET directly so that it reads 0
  // during reset, even though the reset state would otherwise allow a byte.
  always_comb begin
    msg_ready    = 1'b0;
    consume_en   = 1'b0;
    underrun_hit = 1'b0;
    case (state)
      IDLE: msg_ready = !HRESET && !frame_done && (buf_cnt <= 5'd8);
      EMBED: begin
        msg_ready    = !HRESET && !frame_done && (buf_cnt <= 5'd8);
        consume_en   = hsync_in && !frame_done;
        underrun_hit = hsync_in && !frame_done && (buf_cnt < 5'd6);
      end
      DRAIN:   consume_en = hsync_in && !frame_done;
      default: ;
    endcase
  end

  assign accept = msg_valid && msg_ready;

  // Bit buffer update. The next-to-embed bit sits at buf_q[15]. Consumed
  // bits are shifted out at the top. A new byte is placed directly behind
  // the bits that remain, so its MSB follows the older bits.
  always_comb begin
    k = 3'd0;
    if (consume_en) k = (buf_cnt >= 5'd6) ? 3'd6 : buf_cnt[2:0];
    buf_shift = buf_q << k;
    remain    = buf_cnt - {2'b00, k};
    buf_nxt   = buf_shift;
    cnt_nxt   = remain;
    if (accept) begin
      buf_nxt = buf_shift | ({msg_data, 8'h00} >> remain);
      cnt_nxt = remain + 5'd8;
    end
  end

  // Only the first k channels take a message bit. The remaining channels,
  // and all upper bits, pass through untouched.
  always_comb begin
    pix_in[0] = DATA_R0_in;
    pix_in[1] = DATA_G0_in;
    pix_in[2] = DATA_B0_in;
    pix_in[3] = DATA_R1_in;
    pix_in[4] = DATA_G1_in;
    pix_in[5] = DATA_B1_in;
    for (int i = 0; i < 6; i++) begin
      pix_emb[i] = pix_in[i];
      if (3'(i) < k) pix_emb[i] = {pix_in[i][7:1], buf_q[15-i]};
    end
  end

  assign bits_sum = {1'b0, bits_embedded} + (CNT_W+1)'(k);

  // Datapath registers, counters and sticky status flags
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      buf_q         <= '0;
      buf_cnt       <= '0;
      pair_cnt      <= '0;
      hsync_out     <= 1'b0;
      DATA_R0_out   <= '0;
      DATA_G0_out   <= '0;
      DATA_B0_out   <= '0;
      DATA_R1_out   <= '0;
      DATA_G1_out   <= '0;
      DATA_B1_out   <= '0;
      bits_embedded <= '0;
      embed_done    <= 1'b0;
      underrun      <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      buf_q     <= buf_nxt;
      buf_cnt   <= cnt_nxt;
      hsync_out <= hsync_in;
      if (hsync_in) begin
        DATA_R0_out <= pix_emb[0];
        DATA_G0_out <= pix_emb[1];
        DATA_B0_out <= pix_emb[2];
        DATA_R1_out <= pix_emb[3];
        DATA_G1_out <= pix_emb[4];
        DATA_B1_out <= pix_emb[5];
        bits_embedded <= bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
        if (!frame_done) pair_cnt <= pair_cnt + 1'b1;
        if (!frame_done && (pair_cnt == CNT_W'(PAIRS - 1)) && (state_nxt != DONE))
          overflow <= 1'b1;
      end
      if (underrun_hit) underrun <= 1'b1;
      if (state_nxt == DONE) embed_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsb_embed.sv
// ---------------------------------------------------------------------------
// tb_lsb_embed
//   Directed bench for lsb_embed with a 4x2 image, which gives 4 pairs per
//   frame. Each driven pair pushes its hand-derived expected output pair and
//   due cycle onto a scoreboard queue. A negedge monitor pops the queue
//   whenever hsync_out appears.
// ---------------------------------------------------------------------------
module tb_lsb_embed;

  localparam int CNT_W = 22;

  logic             HCLK = 1'b0;
  logic             HRESET = 1'b1;
  logic             hsync_in = 1'b0;
  logic [7:0]       DATA_R0_in = '0, DATA_G0_in = '0, DATA_B0_in = '0;
  logic [7:0]       DATA_R1_in = '0, DATA_G1_in = '0, DATA_B1_in = '0;
  logic             msg_valid = 1'b0;
  logic [7:0]       msg_data = '0;
  logic             msg_last = 1'b0;
  logic             msg_ready;
  logic             hsync_out;
  logic [7:0]       DATA_R0_out, DATA_G0_out, DATA_B0_out;
  logic [7:0]       DATA_R1_out, DATA_G1_out, DATA_B1_out;
  logic [CNT_W-1:0] bits_embedded;
  logic             embed_done, underrun, overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [47:0] pix;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  lsb_embed #(.WIDTH(4), .HEIGHT(2), .CNT_W(CNT_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .hsync_in(hsync_in),
    .DATA_R0_in(DATA_R0_in), .DATA_G0_in(DATA_G0_in), .DATA_B0_in(DATA_B0_in),
    .DATA_R1_in(DATA_R1_in), .DATA_G1_in(DATA_G1_in), .DATA_B1_in(DATA_B1_in),
    .msg_valid(msg_valid), .msg_data(msg_data), .msg_last(msg_last),
    .msg_ready(msg_ready), .hsync_out(hsync_out),
    .DATA_R0_out(DATA_R0_out), .DATA_G0_out(DATA_G0_out), .DATA_B0_out(DATA_B0_out),
    .DATA_R1_out(DATA_R1_out), .DATA_G1_out(DATA_G1_out), .DATA_B1_out(DATA_B1_out),
    .bits_embedded(bits_embedded), .embed_done(embed_done),
    .underrun(underrun), .overflow(overflow)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [47:0] outPix();
    return {DATA_R0_out, DATA_G0_out, DATA_B0_out, DATA_R1_out, DATA_G1_out, DATA_B1_out};
  endfunction

  task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of stimulus starting at a negedge and returns on the next negedge.
  task automatic applyStimulus(input logic hs, input logic [47:0] pix, input logic mv,
                               input logic [7:0] md, input logic ml, input logic [47:0] exp_pix);
    exp_t e;
    hsync_in  = hs;
    {DATA_R0_in, DATA_G0_in, DATA_B0_in, DATA_R1_in, DATA_G1_in, DATA_B1_in} = pix;
    msg_valid = mv;
    msg_data  = md;
    msg_last  = ml;
    if (mv) checkOutput("msg_ready at byte", {47'd0, msg_ready}, 48'd1);
    if (hs) begin
      e.pix = exp_pix;
      e.due = cyc + 1;
      sb.push_back(e);
    end
    @(negedge HCLK);
    hsync_in  = 1'b0;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] md, input logic ml);
    applyStimulus(1'b0, 48'd0, 1'b1, md, ml, 48'd0);
  endtask

  task automatic sendPair(input logic [47:0] pix, input logic [47:0] exp_pix);
    applyStimulus(1'b1, pix, 1'b0, 8'h00, 1'b0, exp_pix);
  endtask

  task automatic doReset();
    HRESET = 1'b1;
    #1;
    checkOutput("reset outputs", {38'd0, hsync_out, embed_done, underrun, overflow, msg_ready, 5'd0}, 48'd0);
    checkOutput("reset data", outPix(), 48'd0);
    checkOutput("reset bits", 48'(bits_embedded), 48'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    sb.delete();
    #1;
    checkOutput("ready after reset", {47'd0, msg_ready}, 48'd1);
    @(negedge HCLK);
  endtask

  // Scoreboard monitor: every hsync_out pops one expected pair and checks
  // both its data and that it arrived exactly one cycle after being driven.
  always @(negedge HCLK) begin
    if (!HRESET) begin
      if (hsync_out) begin
        if (sb.size() == 0) begin
          checkOutput("spurious hsync_out", {47'd0, hsync_out}, 48'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("pair latency", 48'(cyc), 48'(mon_e.due));
          checkOutput("pair data", outPix(), mon_e.pix);
        end
      end else if (sb.size() != 0 && cyc >= sb[0].due) begin
        checkOutput("missing hsync_out", {47'd0, hsync_out}, 48'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    $display("[TB] start");
    @(negedge HCLK);
    doReset();

    // Pass-through with no message, then data must hold while hsync is low
    sendPair(48'h123456789ABC, 48'h123456789ABC);
    @(negedge HCLK);
    checkOutput("passthru hold", outPix(), 48'h123456789ABC);
    checkOutput("passthru bits", 48'(bits_embedded), 48'd0);
    checkOutput("passthru idle ready", {47'd0, msg_ready}, 48'd1);

    // Single-byte message 0xA5
    doReset();
    sendByte(8'hA5, 1'b1);
    sendPair(48'hFFFFFFFFFFFF, 48'hFFFEFFFEFEFF);
    sendPair(48'hFFFFFFFFFFFF, 48'hFEFFFFFFFFFF);
    checkOutput("single bits", 48'(bits_embedded), 48'd8);
    checkOutput("single done", {47'd0, embed_done}, 48'd1);
    checkOutput("single underrun", {47'd0, underrun}, 48'd0);
    checkOutput("single ready", {47'd0, msg_ready}, 48'd0);
    sendPair(48'h000000000000, 48'h000000000000);
    @(negedge HCLK);

    // Underrun: one byte, two pairs
    doReset();
    sendByte(8'hFF, 1'b0);
    sendPair(48'h000000000000, 48'h010101010101);
    sendPair(48'h000000000000, 48'h010100000000);
    checkOutput("underrun flag", {47'd0, underrun}, 48'd1);
    checkOutput("underrun bits", 48'(bits_embedded), 48'd8);
    checkOutput("underrun done", {47'd0, embed_done}, 48'd0);

    // Overflow: 32 bits of message, only 24 fit in a 4-pair frame
    doReset();
    sendByte(8'hFF, 1'b0);
    sendByte(8'hFF, 1'b0);
    sendPair(48'h000000000000, 48'h010101010101);
    sendPair(48'h000000000000, 48'h010101010101);
    sendByte(8'hFF, 1'b0);
    sendPair(48'h000000000000, 48'h010101010101);
    sendByte(8'hFF, 1'b1);
    sendPair(48'h000000000000, 48'h010101010101);
    checkOutput("overflow flag", {47'd0, overflow}, 48'd1);
    checkOutput("overflow done", {47'd0, embed_done}, 48'd0);
    checkOutput("overflow ready", {47'd0, msg_ready}, 48'd0);
    checkOutput("overflow bits", 48'(bits_embedded), 48'd24);
    checkOutput("overflow underrun", {47'd0, underrun}, 48'd0);
    sendPair(48'h000000000000, 48'h000000000000);
    checkOutput("overflow frozen bits", 48'(bits_embedded), 48'd24);

    // Accept and consume in the same cycle
    doReset();
    sendByte(8'hC3, 1'b0);
    applyStimulus(1'b1, 48'h000000000000, 1'b1, 8'h96, 1'b0, 48'h010100000000);
    checkOutput("simul ready full", {47'd0, msg_ready}, 48'd0);
    sendPair(48'h000000000000, 48'h010101000001);
    checkOutput("simul bits", 48'(bits_embedded), 48'd12);
    checkOutput("simul ready", {47'd0, msg_ready}, 48'd1);

    // Reset mid-frame, asserted away from any clock edge
    doReset();
    sendByte(8'hFF, 1'b0);
    sendPair(48'h000000000000, 48'h010101010101);
    #2;
    HRESET = 1'b1;
    #1;
    checkOutput("midreset flags", {42'd0, hsync_out, embed_done, underrun, overflow, msg_ready, 1'b0}, 48'd0);
    checkOutput("midreset data", outPix(), 48'd0);
    checkOutput("midreset bits", 48'(bits_embedded), 48'd0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    #1;
    checkOutput("midreset ready", {47'd0, msg_ready}, 48'd1);
    @(negedge HCLK);
    sendByte(8'h00, 1'b0);
    sendPair(48'hFFFFFFFFFFFF, 48'hFEFEFEFEFEFE);
    checkOutput("midreset restart bits", 48'(bits_embedded), 48'd6);

    @(negedge HCLK);
    checkOutput("scoreboard empty", 48'(sb.size()), 48'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsb_embed.md
Name: lsb_embed

Overview:
- LSB-steganography embedding stage that sits directly upstream of the .bmp write stage, between the image read stage and the writer.
- Receives the even/odd RGB888 pixel-pair stream qualified by hsync and a byte-wide secret-message stream.
- Replaces the LSB of each colour byte with one message bit.
- Forwards the modified pixel pair one cycle later with a matching hsync, so the writer consumes it unchanged.

Parameters:
- WIDTH, 768, image width in pixels (even).
- HEIGHT, 512, image height in rows.
- PAIRS, WIDTH*HEIGHT/2, pixel pairs per frame (derived, localparam).
- CNT_W, 22, width of bit/pair counters (must hold 3*WIDTH*HEIGHT).

Ports:
- HCLK  in  1  clock, all logic on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- hsync_in  in  1  pixel-pair valid from upstream, one pair per asserted cycle.
- DATA_R0/G0/B0_in  in  8 each  even pixel colour bytes.
- DATA_R1/G1/B1_in  in  8 each  odd pixel colour bytes.
- msg_valid  in  1  message byte valid.
- msg_data  in  8  message byte, MSB embedded first.
- msg_last  in  1  qualifies final message byte.
- msg_ready  out  1  block accepts byte when msg_valid&&msg_ready.
- hsync_out  out  1  registered hsync_in.
- DATA_R0/G0/B0_out, DATA_R1/G1/B1_out  out  8 each  embedded pixel pair.
- bits_embedded  out  CNT_W  count of message bits written into pixels.
- embed_done  out  1  sticky: last byte fully embedded.
- underrun  out  1  sticky: pair processed while message active but fewer than 6 bits buffered.
- overflow  out  1  sticky: frame ended (PAIRS pairs seen) before embed_done.

Behaviour:
- Reset (async, HRESET=1): every output 0, msg_ready 0 while in reset; bit buffer empty; state IDLE; pair counter 0.
- Bit buffer: 16-bit shift register plus 5-bit count buf_cnt. msg_ready = (buf_cnt <= 8) && state in {IDLE, EMBED}; combinational from registers.
- An accepted byte is appended behind the existing bits. Its MSB becomes the next-to-embed bit once the older bits are consumed.
- Embedding order per pair: R0, G0, B0, R1, G1, B1. Each channel takes one bit in the order the bits leave the buffer.
- Per hsync_in cycle, k = min(6, buf_cnt) bits are consumed. Consume applies only in EMBED/DRAIN; IDLE/DONE give k=0.
- Only the first k channels get LSB replaced. The remaining channels pass through bit-exact. The upper 7 bits are always unchanged.
- Same-cycle accept and consume is allowed. New buf_cnt = buf_cnt - k + 8*accept; never exceeds 16.
- Latency: exactly 1 cycle. hsync_out(t+1) = hsync_in(t). Data outputs register only when hsync_in=1 and hold otherwise.
- Underrun: set when hsync_in=1 in EMBED with buf_cnt < 6 (partial or zero embed still performed). Not set in DRAIN.
- State machine:
  - IDLE -> EMBED on first accepted byte.
  - EMBED -> DRAIN on an accepted byte with msg_last=1; msg_ready is 0 from the next cycle.
  - DRAIN -> DONE on the cycle buf_cnt reaches 0 after consumption; embed_done=1 the following cycle.
  - DONE: pure pass-through; stays until reset.
  - msg_last on a single byte in IDLE goes IDLE -> DRAIN directly.
- bits_embedded increments by k on each hsync cycle and saturates at all-ones.
- Pair counter increments on hsync_in. When it reaches PAIRS, the frame is complete and later pairs pass through unmodified. If state != DONE at that point, overflow=1 and the buffer is frozen; msg_ready stays 0.
- Reset mid-operation discards buffered bits and returns to IDLE immediately; no partial pair is emitted.

Test Plan (WIDTH=4, HEIGHT=2, PAIRS=4 unless noted):
- Single-byte message: 0xA5 with msg_last, then 2 pairs all 0xFF. Required:
  - Pair1 out R0=FF G0=FE B0=FF R1=FE G1=FE B1=FF.
  - Pair2 out R0=FE G0=FF, rest FF.
  - bits_embedded=8, embed_done=1, underrun=0.
- Latency/pass-through: no message, hsync pulse with pair 0x12,0x34,0x56,0x78,0x9A,0xBC. Required:
  - Identical bytes and hsync_out exactly 1 cycle later.
  - state IDLE, bits_embedded=0.
- Underrun: byte 0xFF (no last), then 2 consecutive pairs of 0x00, then msg stalled. Required:
  - Pair1 all 0x01.
  - Pair2 R0=G0=01, rest 00.
  - underrun=1, bits_embedded=8.
- Overflow: 4 bytes 0xFF (last on 4th), 4 pairs. Required:
  - 24 bits embedded, all channel LSBs 1.
  - After 4th pair overflow=1, embed_done=0, msg_ready=0.
- Simultaneous accept/consume: buf_cnt=8 with msg_valid on the same cycle as hsync. Required:
  - Byte accepted, 6 bits consumed, buf_cnt=10.
  - Next pair embeds the remaining 2 old bits first, then the new byte's MSBs.
- Reset mid-frame: assert HRESET between pair 1 and 2. Required:
  - All outputs 0 asynchronously, msg_ready 0 during reset, then 1 after release in IDLE.
  - bits_embedded restarts from 0.
